affine_mv_gen_seq: RTL and testbench

- Parametrised successor to the single-CU MV generator datapath. Takes one coding-unit descriptor per handshake: position, size, mode (4/6-parameter affine) and 2 or 3 CPMVs.
- Walks every 4x4 subblock of the CU in raster order and emits one subblock MV per output handshake.
- Sits between the CU parser and the interpolation fetch stage.
- Replaces the fixed 4-block counter and the external control FSM with an internal FSM, valid/ready handshakes on both sides, a runtime CU size, and incremental (multiplier-free) MV evaluation.

---
 rtl/affine_mv_gen_seq_pkg.sv | 30 +++
 rtl/affine_mv_gen_seq_if.sv | 48 ++++
 rtl/affine_mv_gen_seq_grad.sv | 47 ++++
 rtl/affine_mv_gen_seq.sv | 140 ++++++++++++++
 tb/tb_affine_mv_gen_seq.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/affine_mv_gen_seq_pkg.sv
// Shared types and helpers for the affine subblock MV generator.
package affine_mv_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

    // Subblocks are 4x4 pixels.
    localparam int SUBBLK_LOG2 = 2;

    // Output MV width: three guard bits cover mv0 plus two full-CU gradient spans.
    function automatic int calc_out_w(input int mv_w);
        return mv_w + 3;
    endfunction

    // Accumulator width: CPMV scaled by 2^SHIFT plus the same guard bits and a sign.
    function automatic int calc_acc_w(input int mv_w, input int shift);
        return mv_w + shift + 4;
    endfunction

    // Clamp a log2 CU side into 3..max_log2.
    function automatic logic [2:0] clamp_log2(input logic [2:0] v, input int max_log2);
        logic [2:0] r;
        r = v;
        if (v < 3'd3)
            r = 3'd3;
        else if (int'(v) > max_log2)
            r = 3'(max_log2);
        return r;
    endfunction

endpackage

// File: rtl/affine_mv_gen_seq_if.sv
// Descriptor-in / subblock-out handshake bundle of the affine MV generator.
interface affine_mv_gen_seq_if #(
    parameter int MV_W    = 8,
    parameter int COORD_W = 8
);
    localparam int OUT_W = affine_mv_pkg::calc_out_w(MV_W);

    // Descriptor side
    logic               IN_VALID;
    logic               IN_READY;
    logic               IN_MODE6;
    logic [2:0]         IN_LOG2_W;
    logic [2:0]         IN_LOG2_H;
    logic [COORD_W-1:0] IN_COORD_X;
    logic [COORD_W-1:0] IN_COORD_Y;
    logic [2*MV_W-1:0]  CPMV_0;
    logic [2*MV_W-1:0]  CPMV_1;
    logic [2*MV_W-1:0]  CPMV_2;

    // Subblock result side
    logic               OUT_VALID;
    logic               OUT_READY;
    logic [COORD_W-1:0] OUT_SB_X;
    logic [COORD_W-1:0] OUT_SB_Y;
    logic [OUT_W-5:0]   OUT_MV_X_INT;
    logic [OUT_W-5:0]   OUT_MV_Y_INT;
    logic [3:0]         OUT_MV_X_FRAC;
    logic [3:0]         OUT_MV_Y_FRAC;
    logic               OUT_INTERP_X;
    logic               OUT_INTERP_Y;
    logic               OUT_LAST;
    logic               BUSY;

    modport master (
        output IN_VALID, IN_MODE6, IN_LOG2_W, IN_LOG2_H, IN_COORD_X, IN_COORD_Y,
               CPMV_0, CPMV_1, CPMV_2, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_SB_X, OUT_SB_Y, OUT_MV_X_INT, OUT_MV_Y_INT,
               OUT_MV_X_FRAC, OUT_MV_Y_FRAC, OUT_INTERP_X, OUT_INTERP_Y, OUT_LAST, BUSY
    );

    modport slave (
        input  IN_VALID, IN_MODE6, IN_LOG2_W, IN_LOG2_H, IN_COORD_X, IN_COORD_Y,
               CPMV_0, CPMV_1, CPMV_2, OUT_READY,
        output IN_READY, OUT_VALID, OUT_SB_X, OUT_SB_Y, OUT_MV_X_INT, OUT_MV_Y_INT,
               OUT_MV_X_FRAC, OUT_MV_Y_FRAC, OUT_INTERP_X, OUT_INTERP_Y, OUT_LAST, BUSY
    );

endinterface

// File: rtl/affine_mv_gen_seq_grad.sv
// Combinational affine gradient and initial-accumulator computation for one CU.
module affine_grad_calc #(
    parameter int MV_W  = 8,
    parameter int SHIFT = 7,
    parameter int ACC_W = 19
) (
    input  logic                    mode6,
    input  logic [2:0]              log2_w,
    input  logic [2:0]              log2_h,
    input  logic [2*MV_W-1:0]       cpmv_0,
    input  logic [2*MV_W-1:0]       cpmv_1,
    input  logic [2*MV_W-1:0]       cpmv_2,
    output logic signed [ACC_W-1:0] dhor_x,
    output logic signed [ACC_W-1:0] dhor_y,
    output logic signed [ACC_W-1:0] dver_x,
    output logic signed [ACC_W-1:0] dver_y,
    output logic signed [ACC_W-1:0] init_x,
    output logic signed [ACC_W-1:0] init_y
);
    logic signed [ACC_W-1:0] m0x, m0y, m1x, m1y, m2x, m2y;
    int sh_w, sh_h;

    // Sign-extend CPMVs, derive gradients, then the centre value of subblock (0,0).
    always_comb begin
        m0x = ACC_W'($signed(cpmv_0[2*MV_W-1:MV_W]));
        m0y = ACC_W'($signed(cpmv_0[MV_W-1:0]));
        m1x = ACC_W'($signed(cpmv_1[2*MV_W-1:MV_W]));
        m1y = ACC_W'($signed(cpmv_1[MV_W-1:0]));
        m2x = ACC_W'($signed(cpmv_2[2*MV_W-1:MV_W]));
        m2y = ACC_W'($signed(cpmv_2[MV_W-1:0]));
        sh_w = SHIFT - int'(log2_w);
        sh_h = SHIFT - int'(log2_h);
        dhor_x = (m1x - m0x) <<< sh_w;
        dhor_y = (m1y - m0y) <<< sh_w;
        if (mode6) begin
            dver_x = (m2x - m0x) <<< sh_h;
            dver_y = (m2y - m0y) <<< sh_h;
        end else begin
            // 4-parameter model: vertical gradient is the horizontal one rotated 90 degrees
            dver_x = -dhor_y;
            dver_y = dhor_x;
        end
        init_x = (m0x <<< SHIFT) + (dhor_x <<< 1) + (dver_x <<< 1);
        init_y = (m0y <<< SHIFT) + (dhor_y <<< 1) + (dver_y <<< 1);
    end

endmodule

// File: rtl/affine_mv_gen_seq.sv
// Affine subblock MV generator: one CU descriptor in, one 4x4 subblock MV out per handshake,
// raster scan, incremental (multiplier-free) evaluation at each subblock centre.
module affine_mv_gen_seq
    import affine_mv_pkg::*;
#(
    parameter int MV_W        = 8,
    parameter int COORD_W     = 8,
    parameter int LOG2_MAX_CU = 7,
    parameter int SHIFT       = 7
) (
    input logic             CLK,
    input logic             RST,
    affine_mv_gen_seq_if.slave bus
);
    localparam int OUT_W = calc_out_w(MV_W);
    localparam int ACC_W = calc_acc_w(MV_W, SHIFT);
    localparam int CNT_W = LOG2_MAX_CU - SUBBLK_LOG2;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (SHIFT - 1));

    state_t state, state_nxt;

    logic               mode6_q;
    logic [2:0]         l2w_q, l2h_q;
    logic [COORD_W-1:0] cx_q, cy_q;
    logic [2*MV_W-1:0]  mv0_q, mv1_q, mv2_q;

    logic signed [ACC_W-1:0] dhx_q, dhy_q, dvx_q, dvy_q;
    logic signed [ACC_W-1:0] rowx_q, rowy_q, curx_q, cury_q;
    logic signed [ACC_W-1:0] g_dhx, g_dhy, g_dvx, g_dvy, g_initx, g_inity;
    logic signed [ACC_W-1:0] rndx, rndy;
    logic signed [OUT_W-1:0] mvx, mvy;

    logic [CNT_W-1:0] i_q, j_q, nw_m1, nh_m1;
    logic last_i, last_j, last_sb, accept, advance;

    affine_grad_calc #(.MV_W(MV_W), .SHIFT(SHIFT), .ACC_W(ACC_W)) u_grad (
        .mode6 (mode6_q), .log2_w(l2w_q), .log2_h(l2h_q),
        .cpmv_0(mv0_q), .cpmv_1(mv1_q), .cpmv_2(mv2_q),
        .dhor_x(g_dhx), .dhor_y(g_dhy), .dver_x(g_dvx), .dver_y(g_dvy),
        .init_x(g_initx), .init_y(g_inity)
    );

    // Scan bounds from the clamped CU size.
    always_comb begin
        nw_m1   = CNT_W'((32'd1 << (l2w_q - 3'd2)) - 32'd1);
        nh_m1   = CNT_W'((32'd1 << (l2h_q - 3'd2)) - 32'd1);
        last_i  = (i_q == nw_m1);
        last_j  = (j_q == nh_m1);
        last_sb = (state == RUN) && last_i && last_j;
        accept  = (state == IDLE) && bus.IN_VALID;
        advance = (state == RUN) && bus.OUT_READY && !last_sb;
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        bus.IN_READY  = 1'b0;
        bus.OUT_VALID = 1'b0;
        bus.BUSY      = 1'b1;
        case (state)
            IDLE: begin
                bus.IN_READY = 1'b1;
                bus.BUSY     = 1'b0;
                if (bus.IN_VALID) state_nxt = SETUP;
            end
            SETUP: state_nxt = RUN;
            RUN: begin
                bus.OUT_VALID = 1'b1;
                if (bus.OUT_READY && last_sb) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Descriptor capture, gradient load and incremental subblock walk.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode6_q <= 1'b0; l2w_q <= '0; l2h_q <= '0; cx_q <= '0; cy_q <= '0;
            mv0_q <= '0; mv1_q <= '0; mv2_q <= '0;
            dhx_q <= '0; dhy_q <= '0; dvx_q <= '0; dvy_q <= '0;
            rowx_q <= '0; rowy_q <= '0; curx_q <= '0; cury_q <= '0;
            i_q <= '0; j_q <= '0;
        end else begin
            if (accept) begin
                mode6_q <= bus.IN_MODE6;
                l2w_q   <= clamp_log2(bus.IN_LOG2_W, LOG2_MAX_CU);
                l2h_q   <= clamp_log2(bus.IN_LOG2_H, LOG2_MAX_CU);
                cx_q    <= bus.IN_COORD_X;
                cy_q    <= bus.IN_COORD_Y;
                mv0_q   <= bus.CPMV_0;
                mv1_q   <= bus.CPMV_1;
                mv2_q   <= bus.CPMV_2;
            end
            if (state == SETUP) begin
                dhx_q <= g_dhx; dhy_q <= g_dhy; dvx_q <= g_dvx; dvy_q <= g_dvy;
                rowx_q <= g_initx; rowy_q <= g_inity;
                curx_q <= g_initx; cury_q <= g_inity;
                i_q <= '0; j_q <= '0;
            end else if (advance) begin
                if (last_i) begin
                    // New row: step the row anchor by one subblock height and restart from it
                    i_q    <= '0;
                    j_q    <= j_q + CNT_W'(1);
                    rowx_q <= rowx_q + (dvx_q <<< 2);
                    rowy_q <= rowy_q + (dvy_q <<< 2);
                    curx_q <= rowx_q + (dvx_q <<< 2);
                    cury_q <= rowy_q + (dvy_q <<< 2);
                end else begin
                    i_q    <= i_q + CNT_W'(1);
                    curx_q <= curx_q + (dhx_q <<< 2);
                    cury_q <= cury_q + (dhy_q <<< 2);
                end
            end
        end
    end

    // Round half toward +inf, then split into integer (arithmetic floor) and 1/16 fraction.
    always_comb begin
        rndx = (curx_q + HALF) >>> SHIFT;
        rndy = (cury_q + HALF) >>> SHIFT;
        mvx  = rndx[OUT_W-1:0];
        mvy  = rndy[OUT_W-1:0];
        bus.OUT_SB_X      = cx_q + COORD_W'({i_q, 2'b00});
        bus.OUT_SB_Y      = cy_q + COORD_W'({j_q, 2'b00});
        bus.OUT_MV_X_INT  = mvx[OUT_W-1:4];
        bus.OUT_MV_Y_INT  = mvy[OUT_W-1:4];
        bus.OUT_MV_X_FRAC = mvx[3:0];
        bus.OUT_MV_Y_FRAC = mvy[3:0];
        bus.OUT_INTERP_X  = |mvx[3:0];
        bus.OUT_INTERP_Y  = |mvy[3:0];
        bus.OUT_LAST      = last_sb;
    end

endmodule

// File: tb/tb_affine_mv_gen_seq.sv
// Directed, table-driven bench for affine_mv_gen_seq.
module tb_affine_mv_gen_seq;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    affine_mv_gen_seq_if #(.MV_W(8), .COORD_W(8)) bus ();
    affine_mv_gen_seq dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct {
        logic [7:0] sbx, sby;
        int         mvx, mvy;
        bit         last;
    } exp_t;

    typedef struct {
        string      name;
        bit         mode6;
        logic [2:0] l2w, l2h;
        logic [7:0] x, y;
        int         m0x, m0y, m1x, m1y, m2x, m2y;
        int         first, cnt;
    } vec_t;

    exp_t ex[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic void add_exp(input int sbx, input int sby, input int mvx, input int mvy,
                                    input bit last);
        exp_t e;
        e.sbx = 8'(sbx); e.sby = 8'(sby); e.mvx = mvx; e.mvy = mvy; e.last = last;
        ex.push_back(e);
    endfunction

    function automatic vec_t mk_vec(input string name, input bit m6, input int l2w, input int l2h,
                                    input int x, input int y, input int m0x, input int m0y,
                                    input int m1x, input int m1y, input int m2x, input int m2y,
                                    input int first, input int cnt);
        vec_t v;
        v.name = name; v.mode6 = m6; v.l2w = 3'(l2w); v.l2h = 3'(l2h);
        v.x = 8'(x); v.y = 8'(y);
        v.m0x = m0x; v.m0y = m0y; v.m1x = m1x; v.m1y = m1y; v.m2x = m2x; v.m2y = m2y;
        v.first = first; v.cnt = cnt;
        return v;
    endfunction

    task automatic check_out(input exp_t e, input string tag);
        chk({tag, " valid"},   int'(bus.OUT_VALID), 1);
        chk({tag, " sb_x"},    int'(bus.OUT_SB_X), int'(e.sbx));
        chk({tag, " sb_y"},    int'(bus.OUT_SB_Y), int'(e.sby));
        chk({tag, " x_int"},   int'($signed(bus.OUT_MV_X_INT)), e.mvx >>> 4);
        chk({tag, " x_frac"},  int'(bus.OUT_MV_X_FRAC), e.mvx & 15);
        chk({tag, " y_int"},   int'($signed(bus.OUT_MV_Y_INT)), e.mvy >>> 4);
        chk({tag, " y_frac"},  int'(bus.OUT_MV_Y_FRAC), e.mvy & 15);
        chk({tag, " interp_x"}, int'(bus.OUT_INTERP_X), int'((e.mvx & 15) != 0));
        chk({tag, " interp_y"}, int'(bus.OUT_INTERP_Y), int'((e.mvy & 15) != 0));
        chk({tag, " last"},    int'(bus.OUT_LAST), int'(e.last));
    endtask

    task automatic send_desc(input vec_t v);
        int n;
        n = 0;
        while (!bus.IN_READY && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({v.name, " in_ready_wait"}, int'(bus.IN_READY), 1);
        bus.IN_VALID   = 1'b1;
        bus.IN_MODE6   = v.mode6;
        bus.IN_LOG2_W  = v.l2w;
        bus.IN_LOG2_H  = v.l2h;
        bus.IN_COORD_X = v.x;
        bus.IN_COORD_Y = v.y;
        bus.CPMV_0     = {8'(v.m0x), 8'(v.m0y)};
        bus.CPMV_1     = {8'(v.m1x), 8'(v.m1y)};
        bus.CPMV_2     = {8'(v.m2x), 8'(v.m2y)};
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        // Cycle 1 after handshake: setup, nothing valid yet
        chk({v.name, " setup_valid"}, int'(bus.OUT_VALID), 0);
        chk({v.name, " setup_ready"}, int'(bus.IN_READY), 0);
        chk({v.name, " setup_busy"},  int'(bus.BUSY), 1);
        @(posedge CLK); #1;
    endtask

    task automatic run_vec(input vec_t v, input int stall_at);
        string tag;
        send_desc(v);
        for (int k = 0; k < v.cnt; k++) begin
            tag = $sformatf("%s[%0d]", v.name, k);
            if (k == stall_at) begin
                bus.OUT_READY  = 1'b0;
                bus.IN_VALID   = 1'b1;
                bus.IN_COORD_X = 8'hAA;
                bus.CPMV_0     = 16'h7F7F;
                for (int s = 0; s < 3; s++) begin
                    check_out(ex[v.first + k], {tag, " stall"});
                    chk({tag, " stall_in_ready"}, int'(bus.IN_READY), 0);
                    @(posedge CLK); #1;
                end
                bus.IN_VALID  = 1'b0;
                bus.OUT_READY = 1'b1;
            end
            check_out(ex[v.first + k], tag);
            @(posedge CLK); #1;
        end
        chk({v.name, " done_in_ready"}, int'(bus.IN_READY), 1);
        chk({v.name, " done_valid"},    int'(bus.OUT_VALID), 0);
        chk({v.name, " done_busy"},     int'(bus.BUSY), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f;
        // Translation, mode 6, 8x8 at (16,8): constant (32,-16)
        f = ex.size();
        add_exp(16, 8, 32, -16, 0); add_exp(20, 8, 32, -16, 0);
        add_exp(16, 12, 32, -16, 0); add_exp(20, 12, 32, -16, 1);
        vecs.push_back(mk_vec("trans", 1, 3, 3, 16, 8, 32, -16, 32, -16, 32, -16, f, 4));
        // Zoom, mode 4, 16x16 at (40,100): mv = (4i+2, 4j+2)
        f = ex.size();
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                add_exp(40 + 4*i, 100 + 4*j, 4*i + 2, 4*j + 2, (i == 3) && (j == 3));
        vecs.push_back(mk_vec("zoom", 0, 4, 4, 40, 100, 0, 0, 16, 0, 0, 0, f, 16));
        // Shear, mode 6, 8x16 at (252,0): x wraps to 0, mvy = 2*(4j+2)
        f = ex.size();
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 2; i++)
                add_exp(252 + 4*i, 4*j, 0, 2*(4*j + 2), (i == 1) && (j == 3));
        vecs.push_back(mk_vec("shear", 1, 3, 4, 252, 0, 0, 0, 0, 0, 0, 32, f, 8));
        // Clamp log2W=1 -> 8 px; mv1=(-1,0): centres give -0.25 -> 0 and -0.75 -> -1
        f = ex.size();
        add_exp(8, 8, 0, 0, 0);   add_exp(12, 8, -1, 0, 0);
        add_exp(8, 12, 0, -1, 0); add_exp(12, 12, -1, -1, 1);
        vecs.push_back(mk_vec("clamp", 0, 1, 3, 8, 8, 0, 0, -1, 0, 5, 5, f, 4));

        bus.IN_VALID = 1'b0; bus.IN_MODE6 = 1'b0; bus.IN_LOG2_W = '0; bus.IN_LOG2_H = '0;
        bus.IN_COORD_X = '0; bus.IN_COORD_Y = '0;
        bus.CPMV_0 = '0; bus.CPMV_1 = '0; bus.CPMV_2 = '0;
        bus.OUT_READY = 1'b1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst in_ready",  int'(bus.IN_READY), 1);
        chk("rst out_valid", int'(bus.OUT_VALID), 0);
        chk("rst out_last",  int'(bus.OUT_LAST), 0);
        chk("rst busy",      int'(bus.BUSY), 0);
        chk("rst sb_x",      int'(bus.OUT_SB_X), 0);
        chk("rst sb_y",      int'(bus.OUT_SB_Y), 0);
        chk("rst x_int",     int'(bus.OUT_MV_X_INT), 0);
        chk("rst y_frac",    int'(bus.OUT_MV_Y_FRAC), 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        foreach (vecs[n]) run_vec(vecs[n], -1);

        // Backpressure on the 2nd output with IN_VALID pulsing during RUN
        run_vec(vecs[0], 1);
        repeat (3) @(posedge CLK);
        #1;
        chk("bp no_phantom_valid", int'(bus.OUT_VALID), 0);
        chk("bp no_phantom_busy",  int'(bus.BUSY), 0);

        // Reset after the 5th output handshake of a 16x16 CU
        send_desc(vecs[1]);
        for (int k = 0; k < 5; k++) begin
            check_out(ex[vecs[1].first + k], $sformatf("rstmid[%0d]", k));
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rstmid out_valid", int'(bus.OUT_VALID), 0);
        chk("rstmid busy",      int'(bus.BUSY), 0);
        chk("rstmid in_ready",  int'(bus.IN_READY), 1);
        chk("rstmid sb_x",      int'(bus.OUT_SB_X), 0);
        run_vec(vecs[0], -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
